// File: rtl/ama_riscv_retire_trace.sv
// Retire trace unit: classifies writeback cycles, counts them, and buffers
// retired {inst, pc, seq} records in a first-word-fall-through FIFO.
module ama_riscv_retire_trace #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_cnt,
    input  logic [31:0]      wbk_inst,
    input  logic [31:0]      wbk_pc,
    input  logic             wbk_stall,
    input  logic             trace_ready,
    output logic             trace_valid,
    output logic [31:0]      trace_inst,
    output logic [31:0]      trace_pc,
    output logic [CNT_W-1:0] trace_seq,
    output logic [CNT_W-1:0] cnt_retired,
    output logic [CNT_W-1:0] cnt_nop,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_drop,
    output logic             overflow,
    output logic             draining
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [31:0] INST_FLUSH = 32'h0000_0000;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        TRACE,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [31:0]      mem_inst [DEPTH];
    logic [31:0]      mem_pc   [DEPTH];
    logic [CNT_W-1:0] mem_seq  [DEPTH];

    logic fifo_empty, fifo_full, empty_nxt;
    logic push_window, qualified;
    logic is_flush, is_nop, is_retire;
    logic push, pop, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

    // Capture is open in TRACE, and in IDLE on the very cycle en rises.
    assign push_window = (state == TRACE) || ((state == IDLE) && en);
    assign qualified   = push_window && en && !wbk_stall;
    assign is_flush    = qualified && (wbk_inst == INST_FLUSH);
    assign is_nop      = qualified && (wbk_inst == INST_NOP);
    assign is_retire   = qualified && !is_flush && !is_nop;

    assign pop  = !fifo_empty && trace_ready;
    assign push = is_retire && (!fifo_full || pop);
    assign drop = is_retire && fifo_full && !pop;

    assign wr_ptr_nxt = wr_ptr + {{(PTR_W-1){1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{(PTR_W-1){1'b0}}, pop};
    assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);

    assign trace_valid = !fifo_empty;
    assign trace_inst  = mem_inst[rd_ptr[IDX_W-1:0]];
    assign trace_pc    = mem_pc[rd_ptr[IDX_W-1:0]];
    assign trace_seq   = mem_seq[rd_ptr[IDX_W-1:0]];
    assign draining    = (state == DRAIN);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (en) state_nxt = TRACE;
            TRACE:   if (!en) state_nxt = empty_nxt ? IDLE : DRAIN;
            DRAIN: begin
                if (en)             state_nxt = TRACE;
                else if (empty_nxt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // NOTE: storage is deliberately not reset; pointers alone define validity,
    // and leaving the array reset-free lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_inst[wr_ptr[IDX_W-1:0]] <= wbk_inst;
            mem_pc[wr_ptr[IDX_W-1:0]]   <= wbk_pc;
            mem_seq[wr_ptr[IDX_W-1:0]]  <= cnt_retired;
        end
    end

    // Clear wins over increments; a push in the same cycle still stamps the
    // pre-clear sequence number.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            cnt_retired <= '0;
            cnt_nop     <= '0;
            cnt_flush   <= '0;
            cnt_drop    <= '0;
            overflow    <= 1'b0;
        end else begin
            if (is_retire) cnt_retired <= sat_inc(cnt_retired);
            if (is_nop)    cnt_nop     <= sat_inc(cnt_nop);
            if (is_flush)  cnt_flush   <= sat_inc(cnt_flush);
            if (drop) begin
                cnt_drop <= sat_inc(cnt_drop);
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ama_riscv_retire_trace.sv
// Directed bench for ama_riscv_retire_trace with a reference scoreboard of
// expected trace entries, compared as the FIFO presents them.
module tb_ama_riscv_retire_trace;

    localparam int DEPTH = 8;
    localparam int CNT_W = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_n, en, clr_cnt, wbk_stall, trace_ready;
    logic [31:0]      wbk_inst, wbk_pc;
    logic             trace_valid, overflow, draining;
    logic [31:0]      trace_inst, trace_pc;
    logic [CNT_W-1:0] trace_seq, cnt_retired, cnt_nop, cnt_flush, cnt_drop;

    ama_riscv_retire_trace #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
        .wbk_inst(wbk_inst), .wbk_pc(wbk_pc), .wbk_stall(wbk_stall),
        .trace_ready(trace_ready), .trace_valid(trace_valid),
        .trace_inst(trace_inst), .trace_pc(trace_pc), .trace_seq(trace_seq),
        .cnt_retired(cnt_retired), .cnt_nop(cnt_nop), .cnt_flush(cnt_flush),
        .cnt_drop(cnt_drop), .overflow(overflow), .draining(draining)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      inst;
        logic [31:0]      pc;
        logic [CNT_W-1:0] seq;
    } entry_t;

    entry_t      sb[$];
    int          checks = 0;
    int          errors = 0;
    int          m_state = 0;        // 0 IDLE, 1 TRACE, 2 DRAIN
    logic [31:0] m_seq = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score the head entry, update the reference model, advance.
    task automatic tick();
        bit     pop, window, retire, full;
        entry_t e;
        if (!rst_n) begin
            sb.delete();
            m_state = 0;
            m_seq   = '0;
            @(posedge clk); #1;
            return;
        end
        chk("valid", {63'd0, trace_valid}, {63'd0, (sb.size() != 0)});
        pop  = (sb.size() != 0) && trace_ready;
        full = (sb.size() == DEPTH);
        if (pop) begin
            e = sb.pop_front();
            chk("head_inst", {32'd0, trace_inst}, {32'd0, e.inst});
            chk("head_pc",   {32'd0, trace_pc},   {32'd0, e.pc});
            chk("head_seq",  {32'd0, trace_seq},  {32'd0, e.seq});
        end
        window = (m_state == 1) || (m_state == 0 && en);
        retire = window && en && !wbk_stall && wbk_inst != 32'h0 && wbk_inst != NOP;
        if (retire) begin
            if (!full || pop) sb.push_back('{wbk_inst, wbk_pc, m_seq});
            if (m_seq != 32'hFFFF_FFFF) m_seq = m_seq + 1;
        end
        if (clr_cnt) m_seq = '0;
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = (sb.size() != 0) ? 2 : 0;
            default: if (en) m_state = 1; else if (sb.size() == 0) m_state = 0;
        endcase
        @(posedge clk); #1;
    endtask

    task automatic chk_cnt(input string tag, input int r, input int n, input int f,
                           input int d, input bit o);
        chk({tag, "_retired"}, {32'd0, cnt_retired}, 64'(r));
        chk({tag, "_nop"},     {32'd0, cnt_nop},     64'(n));
        chk({tag, "_flush"},   {32'd0, cnt_flush},   64'(f));
        chk({tag, "_drop"},    {32'd0, cnt_drop},    64'(d));
        chk({tag, "_ovf"},     {63'd0, overflow},    {63'd0, o});
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr_cnt = 1'b0; wbk_stall = 1'b0;
        trace_ready = 1'b0; wbk_inst = '0; wbk_pc = '0;
        @(posedge clk); #1;
        tick();
        rst_n = 1'b1;
        chk("rst_valid", {63'd0, trace_valid}, 64'd0);
        chk("rst_drain", {63'd0, draining}, 64'd0);
        chk_cnt("rst", 0, 0, 0, 0, 1'b0);

        // Basic retire / nop / flush classification.
        en = 1'b1; trace_ready = 1'b1;
        wbk_inst = 32'h0050_0093; wbk_pc = 32'h100; tick();
        chk("basic_valid", {63'd0, trace_valid}, 64'd1);
        chk("basic_seq", {32'd0, trace_seq}, 64'd0);
        wbk_inst = NOP;           wbk_pc = 32'h104; tick();
        wbk_inst = 32'h0;         wbk_pc = 32'h108; tick();
        chk_cnt("basic", 1, 1, 1, 0, 1'b0);

        // Clear has priority over a same-cycle nop; then fill past full.
        clr_cnt = 1'b1; wbk_inst = NOP; tick();
        clr_cnt = 1'b0;
        chk_cnt("clr1", 0, 0, 0, 0, 1'b0);
        trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wbk_inst = 32'h0010_0093 + 32'(i << 7); wbk_pc = 32'h200 + 32'(4 * i); tick();
        end
        chk_cnt("ovf", 10, 0, 0, 2, 1'b1);
        chk("ovf_head_seq", {32'd0, trace_seq}, 64'd0);

        // Full FIFO with pop and push together: no drop, seq 10 appended.
        trace_ready = 1'b1; wbk_inst = 32'h00A0_0113; wbk_pc = 32'h300; tick();
        chk_cnt("fullpp", 11, 0, 0, 2, 1'b1);
        chk("fullpp_head_seq", {32'd0, trace_seq}, 64'd1);
        en = 1'b0;
        for (int i = 0; i < DEPTH; i++) tick();
        chk("empty_valid", {63'd0, trace_valid}, 64'd0);
        chk("empty_drain", {63'd0, draining}, 64'd0);

        // Drain with backpressure, then release.
        en = 1'b1; trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wbk_inst = 32'h0030_0193 + 32'(i << 7); wbk_pc = 32'h400 + 32'(4 * i); tick();
        end
        en = 1'b0; wbk_inst = 32'h0770_0393;
        tick();
        chk("drain_on", {63'd0, draining}, 64'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("drain_hold", {63'd0, draining}, 64'd1);
        chk("drain_seq", {32'd0, trace_seq}, 64'd11);
        chk("drain_ret", {32'd0, cnt_retired}, 64'd14);
        trace_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("drain_off", {63'd0, draining}, 64'd0);
        chk("drain_empty", {63'd0, trace_valid}, 64'd0);

        // Stall holds counters; clear with a retire keeps pre-clear seq.
        en = 1'b1; wbk_stall = 1'b1; wbk_inst = 32'h0090_0493; wbk_pc = 32'h500;
        for (int i = 0; i < 4; i++) tick();
        chk("stall_ret", {32'd0, cnt_retired}, 64'd14);
        wbk_stall = 1'b0; clr_cnt = 1'b1; tick();
        clr_cnt = 1'b0;
        chk_cnt("clr2", 0, 0, 0, 0, 1'b0);
        chk("clr2_seq", {32'd0, trace_seq}, 64'd14);
        wbk_inst = NOP; tick();
        chk("clr2_nop", {32'd0, cnt_nop}, 64'd1);

        // Reset mid-run with five entries buffered.
        trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wbk_inst = 32'h0010_0513 + 32'(i << 7); wbk_pc = 32'h600 + 32'(4 * i); tick();
        end
        chk("prerst_valid", {63'd0, trace_valid}, 64'd1);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        chk("mrst_valid", {63'd0, trace_valid}, 64'd0);
        chk("mrst_drain", {63'd0, draining}, 64'd0);
        chk_cnt("mrst", 0, 0, 0, 0, 1'b0);
        wbk_inst = 32'h0020_0593; wbk_pc = 32'h700; tick();
        chk("mrst_seq", {32'd0, trace_seq}, 64'd0);
        trace_ready = 1'b1; wbk_inst = NOP; tick();
        en = 1'b0; tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
